// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the TX state encoding.
package UartTxConsts;

  localparam logic [3:0] TXDATA = 4'h0;
  localparam logic [3:0] STATUS = 4'h4;
  localparam logic [3:0] DIV    = 4'h8;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-bus interfaces: the load/store unit is Master, peripherals are Slave.
interface WriteIF;
  logic        valid;
  logic [31:0] addr;
  logic [3:0]  strb;
  logic [31:0] data;

  modport Master (output valid, addr, strb, data);
  modport Slave  (input  valid, addr, strb, data);
endinterface

interface ReadIF;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] data;

  modport Master (output valid, addr, input  data);
  modport Slave  (input  valid, addr, output data);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous byte FIFO with wrap-bit pointers; a pop frees a slot for a
// same-cycle push when full, and a pop while empty is ignored.
module byte_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, DIV/overflow registers,
// TX FIFO and the baud-timed frame state machine.
module mmio_uart_tx
  import UartTxConsts::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic  clk,
  input  logic  rst,
  WriteIF.Slave w_bus,
  ReadIF.Slave  r_bus,
  output logic  txd,
  output logic  tx_empty
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_hit, r_hit, push, pop, ovf_clear;
  logic [1:0]    w_reg;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic [15:0]   div, bit_len;
  logic          overflow, bit_done;

  tx_state_e     state, state_next;
  logic [15:0]   baud_cnt, baud_cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shreg, shreg_next;
  logic          txd_next, tx_empty_next;
  logic          unused_bits;

  assign w_hit     = w_bus.valid && (w_bus.addr[31:4] == BASE_ADDR[31:4]) && (w_bus.strb != 4'b0);
  assign w_reg     = w_bus.addr[3:2];
  assign push      = w_hit && (w_reg == TXDATA[3:2]) && w_bus.strb[0];
  assign ovf_clear = w_hit && (w_reg == STATUS[3:2]) && w_bus.strb[0] && w_bus.data[ST_OVF];
  assign unused_bits = ^{w_bus.addr[1:0], w_bus.strb[3:2], w_bus.data[31:16], r_bus.addr[1:0]};

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (w_bus.data[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= DIV_RESET;
      overflow <= 1'b0;
    end else begin
      if (w_hit && (w_reg == DIV[3:2])) begin
        if (w_bus.strb[0]) div[7:0]  <= w_bus.data[7:0];
        if (w_bus.strb[1]) div[15:8] <= w_bus.data[15:8];
      end
      // A push into a full FIFO is dropped unless the FSM pops in the same cycle.
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (ovf_clear)            overflow <= 1'b0;
    end
  end

  // DIV is sampled only when a bit starts, so a mid-frame write never stretches the current bit.
  assign bit_len  = (div == 16'd0) ? 16'd1 : div;
  assign bit_done = (baud_cnt == 16'd0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next    = state;
    baud_cnt_next = baud_cnt;
    bit_idx_next  = bit_idx;
    shreg_next    = shreg;
    txd_next      = txd;
    pop           = 1'b0;
    if (state != IDLE && !bit_done) baud_cnt_next = baud_cnt - 16'd1;

    case (state)
      IDLE, STOP: begin
        if (state == IDLE || bit_done) begin
          if (!fifo_empty) begin
            state_next    = START;
            pop           = 1'b1;
            shreg_next    = fifo_rdata;
            txd_next      = 1'b0;
            baud_cnt_next = bit_len - 16'd1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      START: begin
        if (bit_done) begin
          state_next    = DATA;
          bit_idx_next  = 3'd0;
          txd_next      = shreg[0];
          baud_cnt_next = bit_len - 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_next = bit_len - 16'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            txd_next     = shreg[bit_idx + 3'd1];
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Staying IDLE implies the FIFO is empty now, so only an incoming push keeps it non-empty.
    tx_empty_next = (state_next == IDLE) && !push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
      tx_empty <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
      txd      <= txd_next;
      tx_empty <= tx_empty_next;
    end
  end

  assign r_hit = r_bus.valid && (r_bus.addr[31:4] == BASE_ADDR[31:4]);

  always_comb begin
    r_bus.data = '0;
    if (r_hit) begin
      case (r_bus.addr[3:2])
        STATUS[3:2]: begin
          r_bus.data[ST_FULL]       = fifo_full;
          r_bus.data[ST_EMPTY]      = fifo_empty;
          r_bus.data[ST_BUSY]       = (state != IDLE);
          r_bus.data[ST_OVF]        = overflow;
          r_bus.data[ST_COUNT +: 8] = 8'(fifo_count);
        end
        DIV[3:2]: r_bus.data[15:0] = div;
        default:  r_bus.data = '0;
      endcase
    end
  end

endmodule
